// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Drain-side companion to a synchronous FIFO whose read data is registered
// (one-cycle read latency). Issues read strobes into the FIFO and re-presents
// the returned words as a valid/ready stream. A 2-entry in-order skid buffer
// absorbs the word that is still in flight when the consumer stalls, so no
// data is lost. With an unstalled consumer the stream runs at one word per
// cycle.
//
// Optional feature (compile-time macro FIFO_RDR_LAST_EN):
//   Adds port out_last and a beat counter 0..BURST_LEN-1 that advances on
//   every accepted word. out_last flags the final beat of each burst.
//
// Parameters:
//   DATA_WIDTH    width of each data word (must match the FIFO)
//   BURST_LEN     beats per burst for out_last (>= 1, only with the macro)
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   en            1 = allowed to issue new FIFO reads
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO read strobe (combinational from out_ready/fifo_empty)
//   fifo_data_out FIFO read data, valid the cycle after an accepted read
//   out_valid     stream word valid
//   out_ready     downstream accepts word
//   out_data      stream word (0 while the buffer is empty)
//   buf_count     skid-buffer occupancy, 0..2
//   out_last      last beat of burst (only with FIFO_RDR_LAST_EN)
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            buf_count
`ifdef FIFO_RDR_LAST_EN
   ,
   output logic                  out_last
`endif
);

   // A read was accepted last cycle; its data is on fifo_data_out now.
   logic                  pending;
   logic [DATA_WIDTH-1:0] slot0;   // head of the queue
   logic [DATA_WIDTH-1:0] slot1;
   logic                  pop;
   logic [1:0]            after_pop;
   logic [2:0]            occupancy;
   logic                  wr_slot;

   assign out_valid = (buf_count != 2'd0);
   assign out_data  = out_valid ? slot0 : '0;
   assign pop       = out_valid && out_ready;

   // Entries left once this cycle's pop has happened; also the slot index
   // that an arriving word lands in, because the queue shifts toward slot0.
   assign after_pop = buf_count - {1'b0, pop};
   assign wr_slot   = after_pop[0];

   // Count the in-flight word as already buffered so a read is only issued
   // when there is guaranteed room for its data one cycle later. Looking at
   // this cycle's pop is what allows one word per cycle in steady state.
   assign occupancy  = 3'(after_pop) + 3'(pending);
   assign fifo_rd_en = !rst && en && !fifo_empty && (occupancy < 3'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_count <= 2'd0;
         pending   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // always_ff reads the pre-edge values regardless of evaluation order.
         buf_count <= after_pop + {1'b0, pending};
         pending   <= fifo_rd_en;
      end
   end

   // NOTE: the data slots are deliberately not reset; buf_count alone decides
   // which entries are meaningful, and out_data is forced to 0 when empty.
   // A pop shifts slot1 forward; a capture in the same cycle targets the slot
   // computed after that shift, and the later assignment wins for slot0.
   always_ff @(posedge clk) begin
      if (pop) begin
         slot0 <= slot1;
      end
      if (pending) begin
         if (wr_slot) begin
            slot1 <= fifo_data_out;
         end else begin
            slot0 <= fifo_data_out;
         end
      end
   end

   // Room is reserved before a read is issued, so the buffer plus the
   // in-flight word can never exceed two entries.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (3'(buf_count) + 3'(pending) <= 3'd2);
      end
   end

`ifdef FIFO_RDR_LAST_EN
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   logic [BEAT_W-1:0] beat;

   always_ff @(posedge clk) begin
      if (rst) begin
         beat <= '0;
      end else if (pop) begin
         beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
   end

   // The counter only moves on pop, so out_last holds while stalled.
   assign out_last = out_valid && (beat == LAST_BEAT);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Self-checking bench for fifo_stream_reader. A behavioural FIFO with
// registered read data drives the DUT (returning random garbage when not
// read). A queue-based reference model predicts out_valid, out_data,
// buf_count, fifo_rd_en (and out_last when FIFO_RDR_LAST_EN is defined)
// every cycle. A table of per-cycle vectors covers streaming and
// backpressure; hand-written sequences cover enable gating, reset and
// mid-flight reset; a random phase exercises everything together.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

   localparam int DW  = 8;
   localparam int BL  = 4;
   localparam int MEM = 2048;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_data_out;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [1:0]    buf_count;
`ifdef FIFO_RDR_LAST_EN
   logic          out_last;
`endif

   always #5 clk = ~clk;

   fifo_stream_reader #(
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_data_out (fifo_data_out),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .buf_count     (buf_count)
`ifdef FIFO_RDR_LAST_EN
      ,
      .out_last      (out_last)
`endif
   );

   // ---------------- behavioural FIFO with registered read data -------------
   logic [DW-1:0] mem [MEM];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   logic          fifo_clr = 1'b0;

   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_clr) begin
         rd_ptr        <= wr_ptr;
         fifo_data_out <= DW'($urandom);
      end else if (fifo_rd_en && !fifo_empty) begin
         fifo_data_out <= mem[rd_ptr % MEM];
         rd_ptr        <= rd_ptr + 1;
      end else begin
         fifo_data_out <= DW'($urandom);   // stale/garbage when not read
      end
   end

   task automatic push(input logic [DW-1:0] d);
      mem[wr_ptr % MEM] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   // ---------------- checking ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] mq [$];          // words held by the skid buffer, head first
   bit            inflight = 0;    // a read was accepted, word not yet landed
   logic [DW-1:0] inflight_word;
   int            beats = 0;       // accepted words since reset
   int            dut_last_pops = 0;
   bit            chk_on = 0;

   // One clock cycle. Called just after a rising edge with inputs already
   // driven; checks at the falling edge, then advances the model.
   task automatic step();
      bit            exp_valid;
      bit            exp_pop;
      bit            exp_rd;
      logic [DW-1:0] exp_data;
      @(negedge clk);
      exp_valid = (mq.size() != 0);
      exp_data  = exp_valid ? mq[0] : '0;
      exp_pop   = exp_valid && out_ready;
      exp_rd    = !rst && en && !fifo_empty &&
                  (mq.size() + int'(inflight) - int'(exp_pop) < 2);
      if (chk_on) begin
         check("model_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
         check("model_valid", 32'(out_valid),  32'(exp_valid));
         check("model_data",  32'(out_data),   32'(exp_data));
         check("model_count", 32'(buf_count),  32'(mq.size()));
`ifdef FIFO_RDR_LAST_EN
         check("model_last", 32'(out_last),
               32'(exp_valid && ((beats % BL) == BL - 1)));
         if (out_valid && out_ready && out_last)
            dut_last_pops = dut_last_pops + 1;
`endif
      end
      if (rst) begin
         mq.delete();
         inflight = 0;
         beats    = 0;
      end else begin
         if (exp_pop) begin
            void'(mq.pop_front());
            beats = beats + 1;
         end
         if (inflight) mq.push_back(inflight_word);
         inflight = exp_rd;
         if (exp_rd) inflight_word = mem[rd_ptr % MEM];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fifo();
      fifo_clr = 1'b1;
      step();
      fifo_clr = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int         load;    // 0 none, 1 = 0x11/0x22/0x33, 2 = 0x01..0x08
      bit         en;
      bit         rdy;
      bit         rd;
      bit         valid;
      bit [7:0]   data;
      bit [1:0]   cnt;
   } vec_t;

   vec_t tbl [20];

   initial begin
      tbl = '{
         // streaming: reads N..N+2, words visible N+2..N+4
         '{1, 1, 1, 1, 0, 8'h00, 2'd0},
         '{0, 1, 1, 1, 0, 8'h00, 2'd0},
         '{0, 1, 1, 1, 1, 8'h11, 2'd1},
         '{0, 1, 1, 0, 1, 8'h22, 2'd1},
         '{0, 1, 1, 0, 1, 8'h33, 2'd1},
         '{0, 1, 1, 0, 0, 8'h00, 2'd0},
         // backpressure: exactly two reads, head held, then in-order drain
         '{2, 1, 0, 1, 0, 8'h00, 2'd0},
         '{0, 1, 0, 1, 0, 8'h00, 2'd0},
         '{0, 1, 0, 0, 1, 8'h01, 2'd1},
         '{0, 1, 0, 0, 1, 8'h01, 2'd2},
         '{0, 1, 0, 0, 1, 8'h01, 2'd2},
         '{0, 1, 1, 1, 1, 8'h01, 2'd2},
         '{0, 1, 1, 1, 1, 8'h02, 2'd1},
         '{0, 1, 1, 1, 1, 8'h03, 2'd1},
         '{0, 1, 1, 1, 1, 8'h04, 2'd1},
         '{0, 1, 1, 1, 1, 8'h05, 2'd1},
         '{0, 1, 1, 1, 1, 8'h06, 2'd1},
         '{0, 1, 1, 0, 1, 8'h07, 2'd1},
         '{0, 1, 1, 0, 1, 8'h08, 2'd1},
         '{0, 1, 1, 0, 0, 8'h00, 2'd0}
      };

      rst       = 1'b1;
      en        = 1'b0;
      out_ready = 1'b0;

      // Settle the DUT before any comparison.
      step();
      step();
      chk_on = 1;

      // ---- reset with data waiting in the FIFO ----
      push(8'hA1); push(8'hA2); push(8'hA3);
      en = 1'b1;
      out_ready = 1'b1;
      #1;
      check("reset_rd_en_c0", 32'(fifo_rd_en), 32'(0));
      step();
      check("reset_rd_en_c1", 32'(fifo_rd_en), 32'(0));
      step();
      rst = 1'b0;
      en  = 1'b0;
      #1;
      check("reset_valid", 32'(out_valid), 32'(0));
      check("reset_data",  32'(out_data),  32'(0));
      check("reset_count", 32'(buf_count), 32'(0));
      clear_fifo();

      // ---- table-driven streaming and backpressure ----
      for (int i = 0; i < 20; i++) begin
         if (tbl[i].load == 1) begin
            push(8'h11); push(8'h22); push(8'h33);
         end else if (tbl[i].load == 2) begin
            for (int k = 1; k <= 8; k++) push(8'(k));
         end
         en        = tbl[i].en;
         out_ready = tbl[i].rdy;
         #1;
         check($sformatf("tbl%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].rd));
         check($sformatf("tbl%0d_valid", i), 32'(out_valid),  32'(tbl[i].valid));
         check($sformatf("tbl%0d_data",  i), 32'(out_data),   32'(tbl[i].data));
         check($sformatf("tbl%0d_count", i), 32'(buf_count),  32'(tbl[i].cnt));
         step();
      end

      // ---- enable gating: en drops right after the first read ----
      push(8'h0A); push(8'h0B); push(8'h0C);
      en = 1'b1;
      out_ready = 1'b1;
      #1;
      check("gate_first_rd", 32'(fifo_rd_en), 32'(1));
      step();
      en = 1'b0;
      #1;
      check("gate_no_rd", 32'(fifo_rd_en), 32'(0));
      step();
      check("gate_word_0a", 32'(out_data), 32'(8'h0A));
      step();
      step();
      check("gate_fifo_left", 32'(wr_ptr - rd_ptr), 32'(2));
      check("gate_idle_valid", 32'(out_valid), 32'(0));
      en = 1'b1;
      for (int k = 0; k < 6; k++) step();
      check("gate_fifo_drained", 32'(wr_ptr - rd_ptr), 32'(0));

      // ---- reset mid-flight: one word buffered, one in flight ----
      // (two buffered plus one in flight cannot occur: room is reserved)
      for (int k = 1; k <= 8; k++) push(8'(8'h20 + k));
      out_ready = 1'b0;
      step();
      step();
      check("mid_count_before", 32'(buf_count), 32'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      check("mid_valid_after", 32'(out_valid), 32'(0));
      check("mid_count_after", 32'(buf_count), 32'(0));
      step();
      step();
      check("mid_next_word", 32'(out_data), 32'(8'h23));
      for (int k = 0; k < 10; k++) step();

`ifdef FIFO_RDR_LAST_EN
      // ---- burst framing with a toggling consumer ----
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_fifo();
      dut_last_pops = 0;
      for (int k = 1; k <= 8; k++) push(8'(8'h40 + k));
      for (int k = 0; k < 30; k++) begin
         out_ready = (k % 2 == 0);
         step();
      end
      check("last_pulses", 32'(dut_last_pops), 32'(2));
`endif

      // ---- randomized traffic against the model ----
      for (int c = 0; c < 1500; c++) begin
         if ((wr_ptr - rd_ptr) < 12 && ($urandom % 2) == 0) push(DW'($urandom));
         en        = (($urandom % 4) != 0);
         out_ready = (($urandom % 3) != 0);
         rst       = (($urandom % 150) == 0);
         step();
      end

      // ---- drain with a bounded wait ----
      rst       = 1'b0;
      en        = 1'b1;
      out_ready = 1'b1;
      begin
         int budget;
         budget = 100;
         while (!(fifo_empty && mq.size() == 0 && !inflight) && budget > 0) begin
            step();
            budget = budget - 1;
         end
         check("drain_done", 32'(budget != 0), 32'(1));
      end
      check("drain_count", 32'(buf_count), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
